fxp_mac_sequencer: RTL and testbench

//  Drives the 16-bit fixed-point Booth multiplier and consumes its product. Accepts operand

---
 rtl/fxp_mac_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fxp_mac_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_mac_sequencer.sv
// Sequencer for the 16-bit Booth multiplier: launches one multiply per operand pair and
// accumulates the Q9.7 products into a dot-product sum. Optional saturation via MAC_SATURATE_EN.
module fxp_mac_sequencer #(
   parameter int W       = 16,
   parameter int TIMEOUT = 31
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_ovf,
   output logic         out_err,
   output logic         mul_start,
   output logic [W-1:0] mul_a,
   output logic [W-1:0] mul_b,
   input  logic [W-1:0] mul_result,
   input  logic         mul_ovf,
   input  logic         mul_finish
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_CLR,
      WAIT_DONE,
      ACCUM,
      EMIT
   } state_t;

   state_t          r_state;
   logic            r_inReady;
   logic            r_outValid;
   logic [W-1:0]    r_acc;
   logic            r_outOvf;
   logic            r_outErr;
   logic            r_mulStart;
   logic [W-1:0]    r_mulA;
   logic [W-1:0]    r_mulB;
   logic            r_lastQ;
   logic [TW-1:0]   r_timer;
   logic [W-1:0]    r_prod;
   logic            r_prodOvf;

   logic [W-1:0]    w_prodEff;
   logic [W:0]      w_sum17;
   logic            w_addOvf;
   logic [W-1:0]    w_accNext;

   // One guard bit is enough to detect signed overflow of the running sum.
   always_comb begin
      w_prodEff = r_prod;
`ifdef MAC_SATURATE_EN
      if (r_prodOvf) begin
         w_prodEff = (r_mulA[W-1] ^ r_mulB[W-1]) ? {1'b1, {(W-1){1'b0}}}
                                                : {1'b0, {(W-1){1'b1}}};
      end
`endif
      w_sum17   = {r_acc[W-1], r_acc} + {w_prodEff[W-1], w_prodEff};
      w_addOvf  = w_sum17[W] ^ w_sum17[W-1];
      w_accNext = w_sum17[W-1:0];
`ifdef MAC_SATURATE_EN
      if (w_addOvf) begin
         w_accNext = w_sum17[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_inReady  <= 1'b0;
         r_outValid <= 1'b0;
         r_acc      <= '0;
         r_outOvf   <= 1'b0;
         r_outErr   <= 1'b0;
         r_mulStart <= 1'b0;
         r_mulA     <= '0;
         r_mulB     <= '0;
         r_lastQ    <= 1'b0;
         r_timer    <= '0;
         r_prod     <= '0;
         r_prodOvf  <= 1'b0;
      end else begin
         r_mulStart <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_inReady && in_valid) begin
                  r_mulA     <= in_a;
                  r_mulB     <= in_b;
                  r_lastQ    <= in_last;
                  r_inReady  <= 1'b0;
                  r_mulStart <= 1'b1;
                  r_state    <= LAUNCH;
               end else begin
                  r_inReady <= 1'b1;
               end
            end
            LAUNCH: begin
               r_timer <= '0;
               r_state <= WAIT_CLR;
            end
            // The finish level from the previous product must drop before a new one counts.
            WAIT_CLR: begin
               if (!mul_finish) begin
                  r_timer <= '0;
                  r_state <= WAIT_DONE;
               end else if (r_timer == TW'(TIMEOUT)) begin
                  r_outErr <= 1'b1;
                  if (r_lastQ) begin
                     r_outValid <= 1'b1;
                     r_state    <= EMIT;
                  end else begin
                     r_inReady <= 1'b1;
                     r_state   <= IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (mul_finish) begin
                  r_prod    <= mul_result;
                  r_prodOvf <= mul_ovf;
                  r_state   <= ACCUM;
               end else if (r_timer == TW'(TIMEOUT)) begin
                  r_outErr <= 1'b1;
                  if (r_lastQ) begin
                     r_outValid <= 1'b1;
                     r_state    <= EMIT;
                  end else begin
                     r_inReady <= 1'b1;
                     r_state   <= IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ACCUM: begin
               r_acc    <= w_accNext;
               r_outOvf <= r_outOvf | r_prodOvf | w_addOvf;
               if (r_lastQ) begin
                  r_outValid <= 1'b1;
                  r_state    <= EMIT;
               end else begin
                  r_inReady <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_acc      <= '0;
                  r_outOvf   <= 1'b0;
                  r_outErr   <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign out_sum   = r_acc;
   assign out_ovf   = r_outOvf;
   assign out_err   = r_outErr;
   assign mul_start = r_mulStart;
   assign mul_a     = r_mulA;
   assign mul_b     = r_mulB;

endmodule

// File: tb/tb_fxp_mac_sequencer.sv
// Self-checking bench for fxp_mac_sequencer: behavioural multiplier stub plus an integer
// dot-product reference model; honours MAC_SATURATE_EN when defined.
module tb_fxp_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [15:0] inA;
   logic [15:0] inB;
   logic        inLast;
   logic        outValid;
   logic        outReady;
   logic [15:0] outSum;
   logic        outOvf;
   logic        outErr;
   logic        mulStart;
   logic [15:0] mulA;
   logic [15:0] mulB;
   logic [15:0] mulResult;
   logic        mulOvf;
   logic        mulFinish;

   int assertCount = 0;
   int failCount   = 0;

   int          mulLat   = 4;
   int          clrDelay = 1;
   bit          stubDead = 1'b0;
   bit          stubBusy;
   int          stubClr;
   int          stubCnt;
   logic [15:0] stubA;
   logic [15:0] stubB;

   int modelAcc;
   bit modelOvf;

   fxp_mac_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_a       (inA),
      .in_b       (inB),
      .in_last    (inLast),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_sum    (outSum),
      .out_ovf    (outOvf),
      .out_err    (outErr),
      .mul_start  (mulStart),
      .mul_a      (mulA),
      .mul_b      (mulB),
      .mul_result (mulResult),
      .mul_ovf    (mulOvf),
      .mul_finish (mulFinish)
   );

   always #5 clk = ~clk;

   // Q9.7 product rounded half-up, flagged when it leaves the 16-bit signed range.
   function automatic logic [16:0] mulModel(input logic [15:0] a, input logic [15:0] b);
      longint p;
      longint r;
      p = longint'($signed(a)) * longint'($signed(b));
      r = (p + 64) >>> 7;
      return {(r > 32767 || r < -32768), r[15:0]};
   endfunction

   // Behavioural multiplier: finish drops clrDelay edges after start, rises mulLat later.
   always @(posedge clk) begin
      if (rst) begin
         mulFinish <= 1'b0;
         mulResult <= '0;
         mulOvf    <= 1'b0;
         stubBusy  <= 1'b0;
         stubClr   <= 0;
         stubCnt   <= 0;
      end else if (stubDead) begin
         mulFinish <= 1'b0;
         stubBusy  <= 1'b0;
      end else if (mulStart && !stubBusy) begin
         stubBusy <= 1'b1;
         stubA    <= mulA;
         stubB    <= mulB;
         stubClr  <= clrDelay;
         stubCnt  <= mulLat;
         if (clrDelay == 0) mulFinish <= 1'b0;
      end else if (stubBusy) begin
         if (stubClr != 0) begin
            stubClr <= stubClr - 1;
            if (stubClr == 1) mulFinish <= 1'b0;
         end else if (stubCnt != 0) begin
            stubCnt <= stubCnt - 1;
         end else begin
            {mulOvf, mulResult} <= mulModel(stubA, stubB);
            mulFinish <= 1'b1;
            stubBusy  <= 1'b0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelAdd(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] m;
      logic [15:0] w;
      int prod;
      int s;
      m    = mulModel(a, b);
      prod = int'($signed(m[15:0]));
`ifdef MAC_SATURATE_EN
      if (m[16]) prod = (a[15] ^ b[15]) ? -32768 : 32767;
`endif
      s = modelAcc + prod;
      if (s > 32767 || s < -32768) begin
         modelOvf = 1'b1;
`ifdef MAC_SATURATE_EN
         s = (s > 0) ? 32767 : -32768;
`else
         w = s[15:0];
         s = int'($signed(w));
`endif
      end
      if (m[16]) modelOvf = 1'b1;
      modelAcc = s;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".inReady"},  inReady,  0);
      checkOutput({tag, ".outValid"}, outValid, 0);
      checkOutput({tag, ".outSum"},   outSum,   0);
      checkOutput({tag, ".outOvf"},   outOvf,   0);
      checkOutput({tag, ".outErr"},   outErr,   0);
      checkOutput({tag, ".mulStart"}, mulStart, 0);
      checkOutput({tag, ".mulA"},     mulA,     0);
      checkOutput({tag, ".mulB"},     mulB,     0);
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic last);
      int n;
      @(negedge clk);
      inValid = 1'b1;
      inA     = a;
      inB     = b;
      inLast  = last;
      n = 0;
      while (!inReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!inReady) begin
         checkOutput("acceptWait", 0, 1);
         inValid = 1'b0;
         return;
      end
      @(negedge clk);
      inValid = 1'b0;
      checkOutput("mulStart", mulStart, 1);
      checkOutput("mulA", mulA, a);
      checkOutput("mulB", mulB, b);
      checkOutput("readyLowBusy", inReady, 0);
   endtask

   task automatic waitSum(input logic [15:0] expSum, input logic expOvf, input logic expErr,
                          input int holdCycles);
      int n;
      n = 0;
      while (!outValid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!outValid) begin
         checkOutput("sumWait", 0, 1);
         return;
      end
      checkOutput("sum", outSum, expSum);
      checkOutput("ovf", outOvf, expOvf);
      checkOutput("err", outErr, expErr);
      inValid = 1'b1;
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         checkOutput("holdValid", outValid, 1);
         checkOutput("holdSum", outSum, expSum);
         checkOutput("holdOvf", outOvf, expOvf);
         checkOutput("holdErr", outErr, expErr);
         checkOutput("holdReady", inReady, 0);
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      checkOutput("validDrop", outValid, 0);
      checkOutput("sumClr", outSum, 0);
      checkOutput("ovfClr", outOvf, 0);
      checkOutput("errClr", outErr, 0);
   endtask

   function automatic logic [15:0] randOperand();
      logic [15:0] v;
      if ($urandom_range(0, 3) == 0) v = 16'($urandom);
      else                           v = 16'($urandom_range(0, 1023)) - 16'd512;
      return v;
   endfunction

   task automatic runDot(input int len);
      logic [15:0] a;
      logic [15:0] b;
      modelAcc = 0;
      modelOvf = 1'b0;
      for (int i = 0; i < len; i++) begin
         a = randOperand();
         b = randOperand();
         modelAdd(a, b);
         mulLat   = $urandom_range(1, 10);
         clrDelay = $urandom_range(0, 2);
         applyStimulus(a, b, (i == len - 1));
      end
      waitSum(modelAcc[15:0], modelOvf, 1'b0, $urandom_range(0, 2));
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      inValid  = 1'b0;
      inA      = '0;
      inB      = '0;
      inLast   = 1'b0;
      outReady = 1'b0;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      rst = 1'b0;

      $display("[TB] T1 single pair 2.0*3.0");
      applyStimulus(16'h0100, 16'h0180, 1'b1);
      waitSum(16'h0300, 1'b0, 1'b0, 0);

      $display("[TB] T2 two pairs");
      applyStimulus(16'h0100, 16'h0180, 1'b0);
      applyStimulus(16'h0080, 16'h0040, 1'b1);
      waitSum(16'h0340, 1'b0, 1'b0, 0);

      $display("[TB] T3 accumulate overflow");
      applyStimulus(16'h0400, 16'h0800, 1'b0);
      applyStimulus(16'h0400, 16'h0800, 1'b1);
`ifdef MAC_SATURATE_EN
      waitSum(16'h7FFF, 1'b1, 1'b0, 0);
`else
      waitSum(16'h8000, 1'b1, 1'b0, 0);
`endif

      $display("[TB] T4 output back-pressure");
      applyStimulus(16'h0100, 16'h0180, 1'b1);
      waitSum(16'h0300, 1'b0, 1'b0, 10);

      $display("[TB] T5 multiplier timeout");
      stubDead = 1'b1;
      repeat (3) @(negedge clk);
      inValid = 1'b1;
      inA     = 16'h0100;
      inB     = 16'h0180;
      inLast  = 1'b1;
      n = 0;
      while (!inReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t5Ready", inReady, 1);
      @(posedge clk);
      #1 inValid = 1'b0;
      n = 0;
      while (!outValid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("timeoutLatency", n, 35);
      waitSum(16'h0000, 1'b0, 1'b1, 0);
      stubDead = 1'b0;

      $display("[TB] T6 reset mid-operation");
      mulLat   = 4;
      clrDelay = 1;
      applyStimulus(16'h0100, 16'h0180, 1'b0);
      mulLat = 10;
      applyStimulus(16'h0080, 16'h0040, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkResetState("midReset");
      rst    = 1'b0;
      mulLat = 4;
      applyStimulus(16'h0100, 16'h0180, 1'b1);
      waitSum(16'h0300, 1'b0, 1'b0, 0);

      $display("[TB] random dot products");
      for (int t = 0; t < 25; t++) begin
         runDot($urandom_range(1, 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
